// File: rtl/clk_25mhz_divider_if.sv
// Carries the divided clock from the divider to the VGA timing/driver logic.
`timescale 1ns/1ps
interface clk_25mhz_divider_if;
  logic CLKOUT;

  modport master (output CLKOUT);
  modport slave  (input  CLKOUT);
endinterface

// File: rtl/clk_25mhz_divider.sv
// Divides CLKIN by DIVIDE into a registered 50% duty clock; first rise on the DIVIDE/2-th edge after release.
// No flow control: free-running whenever ACLR_L is high, cleared low asynchronously.
`timescale 1ns/1ps
module clk_25mhz_divider #(
  parameter int DIVIDE = 4,
  parameter int CNT_W  = 8
) (
  input  logic                 CLKIN,
  input  logic                 ACLR_L,
  clk_25mhz_divider_if.master  out_if
);

  localparam int HALF = DIVIDE / 2;

  if (DIVIDE < 2 || (DIVIDE % 2) != 0) begin : g_bad_divide
    $error("clk_25mhz_divider: DIVIDE must be even and >= 2");
  end

  if ((2 ** CNT_W) < HALF) begin : g_bad_cnt_w
    $error("clk_25mhz_divider: CNT_W too narrow for DIVIDE/2");
  end

  logic clk_q;

  if (HALF == 1) begin : g_div2
    always_ff @(posedge CLKIN or negedge ACLR_L) begin
      if (!ACLR_L) begin
        clk_q <= 1'b0;
      end else begin
        clk_q <= ~clk_q;
      end
    end
  end else begin : g_divn
    localparam logic [CNT_W-1:0] TERM = CNT_W'(HALF - 1);

    logic [CNT_W-1:0] cnt;

    // Anything at or above TERM wraps, so an upset count recovers in one edge.
    always_ff @(posedge CLKIN or negedge ACLR_L) begin
      if (!ACLR_L) begin
        cnt   <= '0;
        clk_q <= 1'b0;
      end else if (cnt >= TERM) begin
        cnt   <= '0;
        clk_q <= ~clk_q;
      end else begin
        cnt   <= cnt + 1'b1;
      end
    end
  end

  assign out_if.CLKOUT = clk_q;

endmodule

// File: tb/tb_clk_25mhz_divider.sv
// Random reset segments on four divider instances; expected CLKOUT edges are queued per instance and matched by a monitor.
`timescale 1ns/1ps
module tb_clk_25mhz_divider;

  localparam int ND = 4;
  localparam int DIVS [ND] = '{2, 4, 6, 10};

  typedef struct {
    longint t;
    logic   v;
  } ev_t;

  logic          CLKIN;
  logic          ACLR_L;
  logic [ND-1:0] clkout;
  logic [ND-1:0] last_v = '0;

  ev_t expq [ND][$];

  int checks   = 0;
  int failures = 0;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    clk_25mhz_divider_if u_if ();

    clk_25mhz_divider #(
      .DIVIDE (DIVS[g]),
      .CNT_W  (8)
    ) u_dut (
      .CLKIN  (CLKIN),
      .ACLR_L (ACLR_L),
      .out_if (u_if.master)
    );

    assign clkout[g] = u_if.CLKOUT;
  end

  initial begin
    CLKIN = 1'b0;
    forever #5 CLKIN = ~CLKIN;
  end

  // Rising CLKIN edge n happens at 5 + 10*n ns.
  // After release at r, the first edge that counts is the first one strictly after r;
  // output toggles on every HALF-th counted edge, and a reset while high forces a fall.
  task automatic plan(input longint r, input longint a);
    for (int d = 0; d < ND; d++) begin
      longint half;
      longint n;
      logic   lvl;
      ev_t    e;
      half = longint'(DIVS[d] / 2);
      n    = (r - 5) / 10 + 1 + half - 1;
      lvl  = 1'b0;
      while (5 + 10 * n < a) begin
        lvl = ~lvl;
        e.t = 5 + 10 * n;
        e.v = lvl;
        expq[d].push_back(e);
        n = n + half;
      end
      if (lvl) begin
        e.t = a;
        e.v = 1'b0;
        expq[d].push_back(e);
      end
    end
  endtask

  task automatic check_all_low(input string name);
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (clkout[d] !== 1'b0) begin
        failures++;
        $display("FAIL %s div=%0d t=%0d: CLKOUT=%b, required 0", name, DIVS[d], $time, clkout[d]);
      end
    end
  endtask

  // Release at r (on_edge: coincident with the CLKIN edge at r, resolving after it),
  // then clear again at a, which is never on a CLKIN edge.
  task automatic run_seg(input longint r, input bit on_edge, input longint a);
    plan(r, a);
    if (on_edge) #(real'(r) - $realtime + 0.001);
    else         #(real'(r) - $realtime);
    ACLR_L = 1'b1;
    #(real'(a) - $realtime);
    ACLR_L = 1'b0;
    #0.5;
    check_all_low("mid_reset");
  endtask

  always @(clkout) begin
    for (int d = 0; d < ND; d++) begin
      if (clkout[d] !== last_v[d]) begin
        if ($time != 0) begin
          checks++;
          if (expq[d].size() == 0) begin
            failures++;
            $display("FAIL edge_unexpected div=%0d: CLKOUT=%b at t=%0d, required no edge",
                     DIVS[d], clkout[d], $time);
          end else begin
            ev_t e;
            e = expq[d].pop_front();
            if (e.t != longint'($time) || e.v !== clkout[d]) begin
              failures++;
              $display("FAIL edge div=%0d: got CLKOUT=%b at t=%0d, required CLKOUT=%b at t=%0d",
                       DIVS[d], clkout[d], $time, e.v, e.t);
            end
          end
        end
        last_v[d] = clkout[d];
      end
    end
  end

  initial begin
    longint now_t;
    longint r;
    longint a;
    bit     oe;

    ACLR_L = 1'b0;
    #10 check_all_low("reset_hold");
    #10 check_all_low("reset_hold");

    // Startup at 30, mid-high clear at 52, long steady run, then a release on an edge.
    run_seg(30, 1'b0, 52);
    run_seg(72, 1'b0, 42012);
    run_seg(42045, 1'b1, 42303);

    for (int s = 0; s < 25; s++) begin
      now_t = longint'($time);
      oe    = 1'($urandom_range(0, 1));
      r     = now_t + longint'($urandom_range(3, 40));
      if (oe) begin
        r = ((r - 5) / 10) * 10 + 5;
        if (r <= now_t) r = r + 10;
      end else if (r % 10 == 5) begin
        r = r + 1;
      end
      a = r + longint'($urandom_range(15, 1500));
      if (a % 10 == 5) a = a + 1;
      run_seg(r, oe, a);
    end

    #100;
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (expq[d].size() != 0) begin
        failures++;
        $display("FAIL missing_edges div=%0d: %0d expected edges never seen, required 0",
                 DIVS[d], expq[d].size());
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
